// File: rtl/alu_issue_pkg.sv
// ALU issue shared definitions: opcodes, ALU class
// encodings, funct3 names and the issue bundle.
package alu_issue_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    CLS_BASE = 2'b00,
    CLS_ALT  = 2'b01,
    CLS_BR   = 2'b10,
    CLS_JMP  = 2'b11
  } alu_cls_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic [5:0]      ctrl;
    logic            br;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] tgt;
    logic [4:0]      rd;
    logic            we;
    logic            ill;
  } iss_t;

  function automatic logic [5:0] alu_ctrl(
    input alu_cls_e   cls,
    input logic [2:0] f3
  );
    return {1'b0, cls, f3};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of one instruction into
// ALU control, operands and control-transfer target.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output iss_t        dec_o
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic [31:0] jalr_sum;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{12{in_instr[31]}}, in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};
  assign imm_b = {{20{in_instr[31]}}, in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign jalr_sum = in_rs1 + imm_i;

  alu_cls_e    cls;
  logic [2:0]  fn;
  logic        legal;
  logic        wr;
  iss_t        d;

  // Per-opcode field selection, then illegal/rd=0 squash
  always_comb begin
    cls   = CLS_BASE;
    fn    = f3;
    legal = 1'b1;
    wr    = 1'b0;
    d     = '0;
    d.rd  = in_instr[11:7];
    unique case (1'b1)
      (opc == OPC_OP): begin
        d.a   = in_rs1;
        d.b   = in_rs2;
        wr    = 1'b1;
        legal = (f7 == F7_BASE) ||
                (f7 == F7_ALT &&
                 (f3 == F3_ADD || f3 == F3_SR));
        if (f7 == F7_ALT) cls = CLS_ALT;
      end
      (opc == OPC_OPIMM): begin
        d.a = in_rs1;
        wr  = 1'b1;
        if (f3 == F3_SLL || f3 == F3_SR)
          d.b = {27'b0, in_instr[24:20]};
        else
          d.b = imm_i;
        if (f3 == F3_SR && f7 == F7_ALT)
          cls = CLS_ALT;
      end
      (opc == OPC_LUI): begin
        fn  = F3_ADD;
        d.b = imm_u;
        wr  = 1'b1;
      end
      (opc == OPC_AUIPC): begin
        fn  = F3_ADD;
        d.a = in_pc;
        d.b = imm_u;
        wr  = 1'b1;
      end
      (opc == OPC_JAL): begin
        cls   = CLS_JMP;
        fn    = F3_ADD;
        d.a   = in_pc;
        d.b   = 32'd4;
        d.tgt = in_pc + imm_j;
        d.br  = 1'b1;
        wr    = 1'b1;
      end
      (opc == OPC_JALR): begin
        legal = (f3 == F3_ADD);
        cls   = CLS_JMP;
        d.a   = in_pc;
        d.b   = 32'd4;
        d.tgt = {jalr_sum[31:1], 1'b0};
        d.br  = 1'b1;
        wr    = 1'b1;
      end
      (opc == OPC_BRANCH): begin
        legal = !(f3 == F3_SLT || f3 == F3_SLTU);
        cls   = CLS_BR;
        d.a   = in_rs1;
        d.b   = in_rs2;
        d.tgt = in_pc + imm_b;
        d.br  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      d.ctrl = alu_ctrl(cls, fn);
      d.we   = wr && (d.rd != 5'd0);
    end else begin
      d      = '0;
      d.rd   = in_instr[11:7];
      d.ill  = 1'b1;
    end
    dec_o = d;
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage toward the ALU: one output register plus
// one skid register behind a registered in_ready.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_ALU_Control,
  output logic        out_branch_op,
  output logic [31:0] out_operand_A,
  output logic [31:0] out_operand_B,
  output logic [31:0] out_target,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
  output logic        out_illegal
);

  iss_t dec;
  iss_t out_q, out_d;
  iss_t skid_q, skid_d;
  logic out_v_q, out_v_d;
  logic skid_v_q, skid_v_d;
  logic rdy_q;
  logic in_fire;
  logic out_free;

  alu_issue_decode u_dec (
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .dec_o    (dec)
  );

  assign in_fire  = in_valid && rdy_q;
  assign out_free = !out_v_q || out_ready;

  // Next state: flush wins, then skid drains first
  always_comb begin
    out_d    = out_q;
    out_v_d  = out_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (out_free) begin
      if (skid_v_q) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = 1'b0;
      end else if (in_fire) begin
        out_d   = dec;
        out_v_d = 1'b1;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d   = dec;
      skid_v_d = 1'b1;
    end
  end

  // State registers; in_ready tracks next skid state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q    <= '0;
      out_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= !skid_v_d;
    end
  end

  assign in_ready        = rdy_q;
  assign out_valid       = out_v_q;
  assign out_ALU_Control = out_q.ctrl;
  assign out_branch_op   = out_q.br;
  assign out_operand_A   = out_q.a;
  assign out_operand_B   = out_q.b;
  assign out_target      = out_q.tgt;
  assign out_rd          = out_q.rd;
  assign out_rd_we       = out_q.we;
  assign out_illegal     = out_q.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized bench for alu_issue against a
// queue-based model with its own instruction decoder.
module tb_alu_issue;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_ALU_Control;
  logic        out_branch_op;
  logic [31:0] out_operand_A;
  logic [31:0] out_operand_B;
  logic [31:0] out_target;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;

  alu_issue dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .in_pc           (in_pc),
    .in_rs1          (in_rs1),
    .in_rs2          (in_rs2),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_ALU_Control (out_ALU_Control),
    .out_branch_op   (out_branch_op),
    .out_operand_A   (out_operand_A),
    .out_operand_B   (out_operand_B),
    .out_target      (out_target),
    .out_rd          (out_rd),
    .out_rd_we       (out_rd_we),
    .out_illegal     (out_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  ctrl;
    logic        br;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] t;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   ready_en = 0;
  bit   acc = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the ISA rules
  function automatic exp_t model(input logic [31:0] i,
                                 input logic [31:0] pc,
                                 input logic [31:0] r1,
                                 input logic [31:0] r2);
    exp_t e;
    int unsigned f3  = i[14:12];
    int unsigned f7  = i[31:25];
    int unsigned cls = 0;
    int unsigned fn  = i[14:12];
    bit legal = 1;
    bit wr = 0;
    logic [20:0] jj = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    logic [12:0] bb = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    logic [31:0] im = 32'($signed(i[31:20]));
    e = '{ctrl: 0, br: 0, a: 0, b: 0, t: 0,
          rd: i[11:7], we: 0, ill: 0};
    case (i[6:0])
      7'h33: begin
        e.a = r1; e.b = r2; wr = 1;
        cls = (f7 == 32) ? 1 : 0;
        legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      end
      7'h13: begin
        e.a = r1; wr = 1;
        e.b = (f3 == 1 || f3 == 5) ? 32'(i[24:20]) : im;
        cls = (f3 == 5 && f7 == 32) ? 1 : 0;
      end
      7'h37: begin e.b = {i[31:12], 12'h0}; fn = 0; wr = 1; end
      7'h17: begin
        e.a = pc; e.b = {i[31:12], 12'h0}; fn = 0; wr = 1;
      end
      7'h6f: begin
        cls = 3; fn = 0; e.a = pc; e.b = 4; e.br = 1; wr = 1;
        e.t = pc + 32'($signed(jj));
      end
      7'h67: begin
        legal = (f3 == 0);
        cls = 3; e.a = pc; e.b = 4; e.br = 1; wr = 1;
        e.t = (r1 + im) & ~32'd1;
      end
      7'h63: begin
        legal = (f3 != 2 && f3 != 3);
        cls = 2; e.a = r1; e.b = r2; e.br = 1;
        e.t = pc + 32'($signed(bb));
      end
      default: legal = 0;
    endcase
    if (legal) begin
      e.ctrl = 6'(cls * 8 + fn);
      e.we = wr && (i[11:7] != 0);
    end else begin
      e.ill = 1;
      e.br = 0;
    end
    return e;
  endfunction

  task automatic check_state();
    chk("ovalid", 32'(out_valid), 32'(q.size() > 0));
    chk("iready", 32'(in_ready),
        32'(ready_en && q.size() < 2));
    if (q.size() > 0) begin
      chk("ctrl", 32'(out_ALU_Control), 32'(q[0].ctrl));
      chk("brop", 32'(out_branch_op), 32'(q[0].br));
      chk("rdwe", 32'(out_rd_we), 32'(q[0].we));
      chk("ill", 32'(out_illegal), 32'(q[0].ill));
      chk("rd", 32'(out_rd), 32'(q[0].rd));
      if (!q[0].ill) begin
        chk("opA", out_operand_A, q[0].a);
        chk("opB", out_operand_B, q[0].b);
        chk("tgt", out_target, q[0].t);
      end
    end
  endtask

  // One cycle: drive, check at negedge, advance model
  task automatic step(input logic v,
                      input logic [31:0] ins,
                      input logic [31:0] pc,
                      input logic [31:0] r1,
                      input logic [31:0] r2,
                      input logic rdy,
                      input logic fl);
    bit rok;
    in_valid = v; in_instr = ins; in_pc = pc;
    in_rs1 = r1; in_rs2 = r2; out_ready = rdy; flush = fl;
    @(negedge clock);
    check_state();
    rok = ready_en && q.size() < 2;
    acc = 0;
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (v && rok) begin
        q.push_back(model(ins, pc, r1, r2));
        acc = 1;
      end
    end
    @(posedge clock);
    #1;
    ready_en = 1;
  endtask

  task automatic idle(input logic rdy);
    step(0, 32'h0, 32'h0, 32'h0, 32'h0, rdy, 0);
  endtask

  function automatic logic [31:0] enc_b(input int imm,
                                        input logic [2:0] f3);
    logic [12:0] m = 13'(imm);
    return {m[12], m[10:5], 5'd2, 5'd1, f3,
            m[4:1], m[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r  = $urandom;
    logic [6:0]  f7 = 7'($urandom);
    int k = $urandom_range(0, 9);
    if ($urandom_range(0, 2) == 0) f7 = 7'h00;
    else if ($urandom_range(0, 1) == 0) f7 = 7'h20;
    case (k)
      0: return {f7, r[24:7], 7'h33};
      1: return {f7, r[24:7], 7'h13};
      2: return {r[31:7], 7'h37};
      3: return {r[31:7], 7'h17};
      4: return {r[31:7], 7'h6f};
      5: return {r[31:15],
                 ($urandom_range(0, 3) == 0) ? r[14:12] : 3'b000,
                 r[11:7], 7'h67};
      6, 7: return {r[31:7], 7'h63};
      default: return r;
    endcase
  endfunction

  localparam logic [31:0] I_ADD  = {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33};
  localparam logic [31:0] I_SRAI = {7'h20, 5'd4, 5'd2, 3'b101, 5'd1, 7'h13};
  localparam logic [31:0] I_ADDI = {12'hC00, 5'd2, 3'b000, 5'd1, 7'h13};
  localparam logic [31:0] I_JALR = {12'd12, 5'd5, 3'b000, 5'd1, 7'h67};

  initial begin
    reset_n = 0; in_valid = 0; in_instr = 0; in_pc = 0;
    in_rs1 = 0; in_rs2 = 0; flush = 0; out_ready = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_iready", 32'(in_ready), 0);
    chk("rst_ctrl", 32'(out_ALU_Control), 0);
    chk("rst_opA", out_operand_A, 0);
    chk("rst_tgt", out_target, 0);
    @(posedge clock);
    #1 reset_n = 1;
    idle(1);
    chk("rel_iready", 32'(in_ready), 1);

    step(1, I_ADD, 32'h0, 32'd5, 32'd7, 1, 0);
    chk("add_ovalid", 32'(out_valid), 1);
    chk("add_ctrl", 32'(out_ALU_Control), 32'h00);
    chk("add_A", out_operand_A, 32'd5);
    chk("add_B", out_operand_B, 32'd7);
    chk("add_rd", 32'(out_rd), 32'd3);
    chk("add_we", 32'(out_rd_we), 1);

    step(1, I_SRAI, 32'h0, 32'h80000000, 32'h0, 1, 0);
    chk("srai_ctrl", 32'(out_ALU_Control), 32'b001101);
    chk("srai_B", out_operand_B, 32'd4);
    step(1, I_ADDI, 32'h0, 32'h1, 32'h0, 1, 0);
    chk("addi_ctrl", 32'(out_ALU_Control), 32'b000000);
    chk("addi_B", out_operand_B, 32'hFFFFFC00);

    step(1, enc_b(-8, 3'b000), 32'h100, 32'h3, 32'h3, 1, 0);
    chk("beq_ctrl", 32'(out_ALU_Control), 32'b010000);
    chk("beq_brop", 32'(out_branch_op), 1);
    chk("beq_tgt", out_target, 32'h0F8);
    chk("beq_we", 32'(out_rd_we), 0);
    step(1, enc_b(-8, 3'b010), 32'h100, 32'h3, 32'h3, 1, 0);
    chk("bill_ill", 32'(out_illegal), 1);
    chk("bill_ctrl", 32'(out_ALU_Control), 0);

    step(1, I_JALR, 32'h40, 32'h2001, 32'h0, 1, 0);
    chk("jalr_ctrl", 32'(out_ALU_Control), 32'b011000);
    chk("jalr_A", out_operand_A, 32'h40);
    chk("jalr_B", out_operand_B, 32'd4);
    chk("jalr_tgt", out_target, 32'h200C);
    idle(1);

    // Three-instruction stream with a two-cycle stall
    step(1, rand_instr(), 32'h10, $urandom, $urandom, 1, 0);
    step(1, rand_instr(), 32'h14, $urandom, $urandom, 0, 0);
    chk("stall_iready", 32'(in_ready), 0);
    begin
      logic [31:0] i3 = rand_instr();
      int n = 0;
      step(1, i3, 32'h18, 32'h5, 32'h6, 0, 0);
      do begin
        step(1, i3, 32'h18, 32'h5, 32'h6, 1, 0);
        n++;
      end while (!acc && n < 6);
      chk("i3_accepted", 32'(acc), 1);
    end
    repeat (3) idle(1);

    // Flush with skid full and a concurrent offer
    step(1, rand_instr(), 32'h20, $urandom, $urandom, 0, 0);
    step(1, rand_instr(), 32'h24, $urandom, $urandom, 0, 0);
    step(1, rand_instr(), 32'h28, $urandom, $urandom, 0, 1);
    chk("fl_ovalid", 32'(out_valid), 0);
    chk("fl_iready", 32'(in_ready), 1);
    repeat (3) idle(1);

    // Reset pulse while stalled with skid full
    step(1, rand_instr(), 32'h30, $urandom, $urandom, 0, 0);
    step(1, rand_instr(), 32'h34, $urandom, $urandom, 0, 0);
    reset_n = 0;
    #1;
    chk("rp_ovalid", 32'(out_valid), 0);
    chk("rp_iready", 32'(in_ready), 0);
    chk("rp_opA", out_operand_A, 0);
    q.delete();
    ready_en = 0;
    @(posedge clock);
    #1 reset_n = 1;
    idle(1);
    chk("rp_rel_iready", 32'(in_ready), 1);

    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) < 7, rand_instr(),
           $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
    end
    repeat (3) idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameters SHALL be none; all widths are fixed (XLEN 32).
REQ-002 clock  in  1  sole clock, rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 in_valid / in_ready  in / out  1 / 1  upstream handshake; transfer when both are high at a clock edge.
REQ-005 in_instr, in_pc, in_rs1, in_rs2  in  32 each  instruction word, its PC, register-file read data.
REQ-006 flush  in  1  synchronous kill of all held entries.
REQ-007 out_valid / out_ready  out / in  1 / 1  downstream handshake toward the ALU stage.
REQ-008 out_ALU_Control  out  6  [5]=0; [4:3]=class (00 base, 01 sub/arith-shift, 10 branch compare, 11 jump); [2:0]=funct3.
REQ-009 out_branch_op  out  1  high for BRANCH, JAL, JALR.
REQ-010 out_operand_A, out_operand_B, out_target  out  32 each  ALU operands; control-transfer target.
REQ-011 out_rd, out_rd_we, out_illegal  out  5/1/1  destination register, write enable, illegal-instruction flag.

Function
REQ-012 OP (0110011): A=rs1, B=rs2, funct3 passed through; class=01 only when funct7=0100000 and funct3 is 000 or 101, otherwise 00; funct7 other than 0000000/0100000, or 0100000 with any other funct3, SHALL be illegal.
REQ-013 OP-IMM (0010011): A=rs1, B=sign-extended imm_I; for funct3 001/101, B=zero-extended shamt[4:0] and class=01 only for SRAI (imm[11:5]=0100000); ADDI SHALL always be class 00 regardless of imm[10].
REQ-014 LUI: class 00 ADD, A=0, B={imm[31:12],12'b0}; AUIPC: A=pc, same B.
REQ-015 JAL: class 11, A=pc, B=4, target=pc+sign-extended imm_J; JALR (funct3 must be 000): class 11, A=pc, B=4, target=(rs1+imm_I) with bit 0 cleared.
REQ-016 BRANCH: class 10, A=rs1, B=rs2, target=pc+imm_B, rd_we=0; funct3 010/011 SHALL be illegal.
REQ-017 rd_we=1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR and SHALL be forced 0 when rd=0 or illegal.
REQ-018 Any other opcode SHALL be illegal; illegal entries pass through with ALU_Control=0, branch_op=0, rd_we=0, out_illegal=1.
REQ-019 Non-target outputs for non-jump/branch entries: target=0.
REQ-020 Storage: one output register plus one skid register; latency in_valid->out_valid SHALL be exactly 1 cycle when not stalled.
REQ-021 in_ready SHALL be a registered signal equal to NOT skid_full; no combinational in_ready<-out_ready path.
REQ-022 Stall: input arriving while out_valid=1 and out_ready=0 SHALL be captured in the skid register; once the output is accepted, the skid entry SHALL advance to output on the next edge.
REQ-023 Simultaneous output accept and input accept with empty skid SHALL load the output register directly; ordering SHALL be strictly FIFO; no entry lost or duplicated.
REQ-024 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 flush SHALL clear both entries at the edge (out_valid=0, skid empty, in_ready=1 next cycle) and SHALL drop any input transferred in the same cycle; flush has priority over all other events.

Reset
REQ-026 reset_n low SHALL asynchronously force out_valid=0, skid empty, in_ready=0 during reset and 1 the first cycle after release; all data outputs SHALL reset to 0.

Structure
REQ-027 Opcode constants, ALU class encodings and funct3 names SHALL live in a shared package also used by the ALU.
REQ-028 Decode SHALL be a combinational sub-module alu_issue_decode feeding both registers; alu_issue holds only the skid/handshake logic.

Verification
REQ-029 add x3,x1,x2 with rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, ALU_Control=000000, A=5, B=7, rd=3, rd_we=1.
REQ-030 srai x1,x2,4 then addi x1,x2,-1024 -> ALU_Control 001101 with B=4, then 000000 with B=0xFFFFFC00.
REQ-031 beq pc=0x100, imm=-8 -> ALU_Control 010000, branch_op=1, target=0x0F8, rd_we=0; funct3=010 branch -> out_illegal=1, ALU_Control=0.
REQ-032 jalr x1,12(x5), rs1=0x2001, pc=0x40 -> ALU_Control 011000, A=0x40, B=4, target=0x200C.
REQ-033 Back-to-back stream of 3 instructions, out_ready low 2 cycles mid-stream -> in_ready drops one cycle after skid fills, all 3 delivered in order, outputs stable while stalled.
REQ-034 flush asserted with skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and concurrently offered instructions never appear; reset_n pulsed mid-stall gives the same empty state.
